// File: rtl/i2s_stream_ctrl.sv
// Frame scheduler for the I2S transmit path: round-robin arbitration of two
// stereo sources into a small frame FIFO, drained into the transmitter core.
module i2s_stream_ctrl #(
  parameter int SW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mute_en,
  input  logic                     clr_underrun,
  input  logic                     s0_valid,
  input  logic [2*SW-1:0]          s0_data,
  output logic                     s0_ready,
  input  logic                     s1_valid,
  input  logic [2*SW-1:0]          s1_data,
  output logic                     s1_ready,
  output logic [2*SW-1:0]          tx_data,
  output logic                     tx_load,
  input  logic                     tx_empty,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CW-1:0]            underrun_cnt,
  output logic                     busy,
  output logic [1:0]               fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = 2 * SW;
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Handshakes: a source frame moves when sN_valid & sN_ready in the same
  // cycle; the transmitter takes tx_data on the single-cycle tx_load strobe
  // and signals consumption by dropping and then raising tx_empty.

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [AW-1:0]   wr_idx_q, wr_idx_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [AW:0]     level_q, level_d;
  logic [FW-1:0]   tx_data_q, tx_data_d;
  logic [CW-1:0]   ucnt_q, ucnt_d;
  logic [FW-1:0]   mem_q [DEPTH];

  logic            full, empty;
  logic            grant0, grant1;
  logic            push0, push1, push;
  logic [FW-1:0]   push_data;
  logic            pop, mute_ins;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  // Pointer only breaks ties; a lone valid source always wins.
  assign grant0   = s0_valid & (~s1_valid | ~ptr_q);
  assign grant1   = s1_valid & (~s0_valid |  ptr_q);
  assign s0_ready = grant0 & ~full;
  assign s1_ready = grant1 & ~full;
  assign push0    = s0_valid & s0_ready;
  assign push1    = s1_valid & s1_ready;
  assign push     = push0 | push1;
  assign push_data = push1 ? s1_data : s0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en && tx_empty && (!empty || mute_en)) state_d = S_LOAD;
      S_LOAD:  state_d = S_ACK;
      S_ACK:   if (!tx_empty) state_d = S_DRAIN;
      S_DRAIN: if (tx_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    mute_ins = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && tx_empty) begin
          if (!empty)       pop      = 1'b1;
          else if (mute_en) mute_ins = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign tx_load   = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign fsm_state = state_q;

  always_comb begin
    ptr_d     = ptr_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    level_d   = level_q;
    tx_data_d = tx_data_q;
    ucnt_d    = ucnt_q;
    if (push0) ptr_d = 1'b1;
    if (push1) ptr_d = 1'b0;
    if (push) wr_idx_d = wr_idx_q + AW'(1);
    if (pop)  rd_idx_d = rd_idx_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (pop)           tx_data_d = mem_q[rd_idx_q];
    else if (mute_ins) tx_data_d = '0;
    // Clear wins over a same-cycle silent-frame increment.
    if (clr_underrun)                  ucnt_d = '0;
    else if (mute_ins && ucnt_q != '1) ucnt_d = ucnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      level_q   <= '0;
      tx_data_q <= '0;
      ucnt_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      level_q   <= level_d;
      tx_data_q <= tx_data_d;
      ucnt_q    <= ucnt_d;
    end
  end

  // Storage needs no reset: resetting the indices discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx_q] <= push_data;
  end

  assign tx_data      = tx_data_q;
  assign fifo_level   = level_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Directed and randomized checks of i2s_stream_ctrl against a queue-based
// model of the frame stream, arbitration fairness and underrun counting.
module tb_i2s_stream_ctrl;
  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int FW    = 2 * SW;
  localparam int UMAX  = (1 << CW) - 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic          clk, rst, en, mute_en, clr_underrun;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [FW-1:0] s0_data, s1_data, tx_data;
  logic          tx_load, tx_empty, busy;
  logic [2:0]    fifo_level;
  logic [CW-1:0] underrun_cnt;
  logic [1:0]    fsm_state;

  i2s_stream_ctrl #(.SW(SW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mute_en(mute_en), .clr_underrun(clr_underrun),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt), .busy(busy),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: frames accepted but not yet loaded, in order.
  logic [FW-1:0] exp_q[$];
  logic          m_ptr;
  logic [FW-1:0] m_txd;
  int            m_ucnt;
  logic          pend_v, pend_clr;
  logic [FW-1:0] pend_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 0; mute_en = 0; clr_underrun = 0; tx_empty = 0;
    s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
    #2;
    chk("rst_tx_load", tx_load, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun", underrun_cnt, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    m_ptr = 0; m_txd = '0; m_ucnt = 0; pend_v = 0; pend_clr = 0; pend_d = '0;
  endtask

  // Called just after a clock edge: retire a load and commit last cycle's push.
  task automatic model_edge();
    if (tx_load) begin
      if (exp_q.size() > 0) m_txd = exp_q.pop_front();
      else begin
        m_txd = '0;
        if (m_ucnt < UMAX) m_ucnt++;
      end
    end
    if (pend_clr) m_ucnt = 0;
    if (pend_v) exp_q.push_back(pend_d);
    pend_v = 0;
    pend_clr = 0;
    chk("tx_data", tx_data, m_txd);
    chk("fifo_level", fifo_level, exp_q.size());
    chk("underrun_cnt", underrun_cnt, m_ucnt);
  endtask

  // Drive one cycle of inputs, check readiness, record the expected push.
  task automatic model_drive(input logic v0, input logic [FW-1:0] d0,
                             input logic v1, input logic [FW-1:0] d1,
                             input logic clr, input logic en_v,
                             input logic mute_v, input logic txe_v,
                             output int acc);
    logic g0, g1, full;
    s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1;
    clr_underrun = clr; en = en_v; mute_en = mute_v; tx_empty = txe_v;
    #1;
    full = (exp_q.size() >= DEPTH);
    g0 = v0 && (!v1 || m_ptr == 1'b0);
    g1 = v1 && (!v0 || m_ptr == 1'b1);
    chk("s0_ready", s0_ready, g0 && !full);
    chk("s1_ready", s1_ready, g1 && !full);
    if (g0 && !full) begin pend_v = 1; pend_d = d0; m_ptr = 1; end
    else if (g1 && !full) begin pend_v = 1; pend_d = d1; m_ptr = 0; end
    pend_clr = clr;
    acc = -1;
    if (s0_valid && s0_ready) acc = 0;
    else if (s1_valid && s1_ready) acc = 1;
  endtask

  task automatic to_idle(input logic mute_v);
    int acc;
    for (int i = 0; i < 20; i++) begin
      if (fsm_state == ST_IDLE) break;
      model_drive(0, '0, 0, '0, 0, 1, mute_v, fsm_state == ST_DRAIN, acc);
      cyc();
      model_edge();
    end
    chk("to_idle", fsm_state, ST_IDLE);
  endtask

  initial begin
    int acc, last, cnt0, cnt1, k, loads, first_chk;
    logic [FW-1:0] f;

    // Single frame through the path.
    do_reset();
    model_drive(1, 32'h1234_ABCD, 0, '0, 0, 1, 0, 1, acc);
    chk("single_acc", acc, 0);
    cyc(); model_edge();
    chk("single_no_load_yet", tx_load, 0);
    model_drive(0, '0, 0, '0, 0, 1, 0, 1, acc);
    cyc(); model_edge();
    chk("single_load", tx_load, 1);
    chk("single_data", tx_data, 32'h1234_ABCD);
    chk("single_busy", busy, 1);
    model_drive(0, '0, 0, '0, 0, 1, 0, 0, acc);
    cyc(); model_edge();
    chk("single_one_pulse", tx_load, 0);
    to_idle(0);

    // Fairness with both sources always valid.
    do_reset();
    last = -1; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 300 && cnt0 + cnt1 < 16; c++) begin
      model_drive(1, 32'hA000_0000 | c, 1, 32'hB000_0000 | c, 0, 1, 0,
                  1'($urandom_range(0, 1)), acc);
      if (acc >= 0) begin
        if (last < 0) chk("fair_first", acc, 0);
        else chk("fair_alternate", acc, 1 - last);
        if (acc == 0) cnt0++; else cnt1++;
        last = acc;
      end
      cyc(); model_edge();
    end
    chk("fair_s0_count", cnt0, 8);
    chk("fair_s1_count", cnt1, 8);

    // Full boundary: five frames into a four-deep FIFO with en low.
    do_reset();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      f = 32'hC0DE_0000 + k;
      model_drive(k < 5, f, 0, '0, 0, 0, 0, 1, acc);
      if (acc == 0) k++;
      cyc(); model_edge();
    end
    chk("full_accepted", k, 4);
    model_drive(1, 32'hC0DE_0004, 0, '0, 0, 0, 0, 1, acc);
    chk("full_ready_low", s0_ready, 0);
    chk("full_level", fifo_level, 4);
    cyc(); model_edge();
    loads = 0; first_chk = 0;
    for (int c = 0; c < 80; c++) begin
      f = 32'hC0DE_0000 + k;
      model_drive(k < 5, f, 0, '0, 0, 1, 0, 1'($urandom_range(0, 1)), acc);
      if (loads == 1 && first_chk == 0) begin
        chk("fifth_after_pop", s0_ready, 1);
        first_chk = 1;
      end
      if (acc == 0) k++;
      cyc(); model_edge();
      if (tx_load) loads++;
    end
    chk("full_all_loaded", loads, 5);
    chk("full_all_pushed", k, 5);

    // Underrun with mute, saturation, and clear priority.
    do_reset();
    loads = 0;
    for (int c = 0; c < 60; c++) begin
      model_drive(0, '0, 0, '0, 0, 1, 1, 1'($urandom_range(0, 1)), acc);
      cyc(); model_edge();
      if (tx_load) begin
        loads++;
        chk("mute_zero_frame", tx_data, 0);
      end
    end
    chk("mute_loads", loads >= 4, 1);
    chk("mute_saturated", underrun_cnt, UMAX);
    to_idle(1);
    model_drive(0, '0, 0, '0, 1, 1, 1, 0, acc);
    cyc(); model_edge();
    chk("clr_alone", underrun_cnt, 0);
    model_drive(0, '0, 0, '0, 0, 1, 1, 1, acc);
    cyc(); model_edge();
    chk("mute_inc_load", tx_load, 1);
    chk("mute_inc_one", underrun_cnt, 1);
    to_idle(1);
    model_drive(0, '0, 0, '0, 1, 1, 1, 1, acc);
    cyc(); model_edge();
    chk("clr_vs_inc_load", tx_load, 1);
    chk("clr_vs_inc", underrun_cnt, 0);
    to_idle(1);

    // Underrun without mute: stay idle.
    for (int c = 0; c < 6; c++) begin
      model_drive(0, '0, 0, '0, 0, 1, 0, 1, acc);
      cyc(); model_edge();
      chk("nomute_no_load", tx_load, 0);
      chk("nomute_idle", busy, 0);
    end

    // Reset in the middle of a handshake with frames queued.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      model_drive(1, 32'hD00D_0000 + c, 0, '0, 0, 0, 0, 1, acc);
      cyc(); model_edge();
    end
    model_drive(0, '0, 0, '0, 0, 1, 0, 1, acc);
    cyc(); model_edge();
    chk("midrst_load", tx_load, 1);
    model_drive(0, '0, 0, '0, 0, 1, 0, 0, acc);
    cyc(); model_edge();
    chk("midrst_in_ack", fsm_state, ST_ACK);
    chk("midrst_queued", fifo_level, 2);
    rst = 1'b0;
    #2;
    chk("midrst_tx_load", tx_load, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_state", fsm_state, ST_IDLE);
    do_reset();
    loads = 0;
    for (int c = 0; c < 10; c++) begin
      model_drive(0, '0, 0, '0, 0, 1, 0, 1, acc);
      cyc(); model_edge();
      if (tx_load) loads++;
    end
    chk("midrst_no_load", loads, 0);
    model_drive(0, '0, 1, 32'h5A5A_0001, 0, 1, 0, 1, acc);
    cyc(); model_edge();
    for (int c = 0; c < 10; c++) begin
      model_drive(0, '0, 0, '0, 0, 1, 0, 1'($urandom_range(0, 1)), acc);
      cyc(); model_edge();
      if (tx_load) loads++;
    end
    chk("midrst_new_load", loads, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      model_drive(1'($urandom_range(0, 1)), FW'($urandom),
                  1'($urandom_range(0, 1)), FW'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      cyc(); model_edge();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
